mux_4_1_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit output channel between four requesters. It registers the 4:1 mux select and holds a grant for a burst of up to MAX_BURST transfers, then rotates priority. The data path is one mux_4_1 instance driven by the registered select. The block sits between four producer ports and a single valid/ready consumer.

---
 rtl/mux_4_1_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - round-robin burst arbiter sharing one channel across four requesters

module mux_4_1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mux_4_1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       ack,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [0:0] state;
    logic [1:0] last;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic [1:0] pick;
    logic       found;
    logic       xfer;
    logic       release_now;

    // First requester in rotating order last+1 .. last+4 (last itself comes last).
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[last + 2'(k)]) begin
                pick  = last + 2'(k);
                found = 1'b1;
            end
        end
    end

    assign busy        = (state == ST_GRANT);
    assign out_valid   = busy & req[sel];
    assign xfer        = out_valid & out_ready;
    assign ack         = xfer ? (4'b0001 << sel) : 4'b0000;
    assign cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign release_now = !req[sel] || (xfer && (cnt_inc == BURST_LIM));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
            last  <= 2'd3;
            sel   <= 2'd0;
            grant <= 4'b0000;
            cnt   <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (found) begin
                state <= ST_GRANT;
                sel   <= pick;
                grant <= 4'b0001 << pick;
                cnt   <= 4'd0;
            end
        end else if (release_now) begin
            state <= ST_IDLE;
            last  <= sel;
            grant <= 4'b0000;
            cnt   <= 4'd0;
        end else if (xfer) begin
            cnt <= cnt_inc;
        end
    end

    mux_4_1 #(.WIDTH(WIDTH)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (sel),
        .y   (out_data)
    );
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb/tb_mux_4_1_rr_arbiter.sv - directed bench for mux_4_1_rr_arbiter

module tb_mux_4_1_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_b;
    logic [3:0] req, req1;
    logic [7:0] d0, d1, d2, d3;
    logic       out_ready;
    logic       out_valid, out_valid1;
    logic [7:0] out_data, out_data1;
    logic [3:0] ack, ack1, grant, grant1;
    logic [1:0] sel, sel1;
    logic       busy, busy1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux_4_1_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .ack(ack), .grant(grant), .sel(sel), .busy(busy)
    );

    mux_4_1_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .req(req1), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_ready(out_ready), .out_valid(out_valid1), .out_data(out_data1),
        .ack(ack1), .grant(grant1), .sel(sel1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dval(input int idx);
        case (idx)
            0: return 8'h5A;
            1: return 8'hA1;
            2: return 8'hC2;
            default: return 8'h3D;
        endcase
    endfunction

    // n transfer cycles for requester idx, then the one idle cycle, ending at the next grant.
    task automatic burst(input int idx, input int n);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("b%0d_grant%0d", idx, i), grant, oh);
            chk($sformatf("b%0d_valid%0d", idx, i), out_valid, 1'b1);
            chk($sformatf("b%0d_ack%0d", idx, i), ack, oh);
            chk($sformatf("b%0d_data%0d", idx, i), out_data, dval(idx));
            tick();
        end
        #1;
        chk($sformatf("b%0d_idle_grant", idx), grant, 4'b0000);
        chk($sformatf("b%0d_idle_valid", idx), out_valid, 1'b0);
        chk($sformatf("b%0d_idle_busy", idx), busy, 1'b0);
        chk($sformatf("b%0d_idle_data", idx), out_data, dval(idx));
        tick();
    endtask

    initial begin
        rst_b = 1'b0; req = 4'b0000; req1 = 4'b0000; out_ready = 1'b0;
        d0 = 8'h5A; d1 = 8'hA1; d2 = 8'hC2; d3 = 8'h3D;
        tick();
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_sel", sel, 2'd0);

        // single requester, full burst, fresh grant after idle cycle
        rst_b = 1'b1; req = 4'b0001; out_ready = 1'b1;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", out_valid, 1'b0);
        tick();
        chk("first_busy", busy, 1'b1);
        burst(0, 4);
        #1;
        chk("regrant0", grant, 4'b0001);

        // all requesting: 0,1,2,3,0
        req = 4'b1111;
        burst(0, 4);
        burst(1, 4);
        burst(2, 4);
        burst(3, 4);
        burst(0, 4);
        #1;
        chk("rr_next1", grant, 4'b0010);

        // requester 1 dropping releases it; requester 2 granted, drops after 2 transfers
        req = 4'b0100;
        #1;
        chk("drop1_valid", out_valid, 1'b0);
        chk("drop1_ack", ack, 4'b0000);
        tick();
        chk("drop1_idle", grant, 4'b0000);
        tick();
        chk("g2_grant", grant, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("g2_ack%0d", i), ack, 4'b0100);
            tick();
        end
        req = 4'b1000;
        #1;
        chk("g2_drop_valid", out_valid, 1'b0);
        chk("g2_drop_ack", ack, 4'b0000);
        chk("g2_drop_grant", grant, 4'b0100);
        tick();
        chk("g2_rel_grant", grant, 4'b0000);
        chk("g2_rel_sel", sel, 2'd2);
        tick();
        chk("after2_grant3", grant, 4'b1000);
        req = 4'b0001;
        tick();
        chk("g3_rel", grant, 4'b0000);
        tick();
        chk("wrap_grant0", grant, 4'b0001);

        // stall on requester 1 with req=0011
        req = 4'b0011;
        burst(0, 4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall_grant%0d", i), grant, 4'b0010);
            chk($sformatf("stall_ack%0d", i), ack, 4'b0000);
            chk($sformatf("stall_valid%0d", i), out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        burst(1, 4);
        #1;
        chk("post_stall_grant0", grant, 4'b0001);

        // reset mid-burst of requester 3
        req = 4'b1000;
        tick();
        chk("to3_idle", grant, 4'b0000);
        tick();
        chk("g3b_grant", grant, 4'b1000);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("g3b_ack%0d", i), ack, 4'b1000);
            tick();
        end
        req = 4'b1001;
        rst_b = 1'b0;
        #1;
        chk("arst_grant", grant, 4'b0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ack", ack, 4'b0000);
        chk("arst_valid", out_valid, 1'b0);
        tick();
        rst_b = 1'b1;
        tick();
        chk("post_rst_grant0", grant, 4'b0001);

        // MAX_BURST = 1 instance alternates 0,2,0,2
        req = 4'b0000;
        req1 = 4'b0101;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mb1_grant%0d", i), grant1, (i % 2 == 0) ? 4'b0001 : 4'b0100);
            chk($sformatf("mb1_ack%0d", i), ack1, (i % 2 == 0) ? 4'b0001 : 4'b0100);
            tick();
            #1;
            chk($sformatf("mb1_idle%0d", i), out_valid1, 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
